// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial line, enable and received-frame outputs of
// the UART receiver.
//   uart_rxd          serial input (idles high)
//   uart_rx_en        permits new start bits to be recognised
//   uart_rx_valid     one-cycle pulse, uart_rx_data holds a good frame
//   uart_rx_data      last received payload
//   uart_rx_frame_err one-cycle pulse, a stop bit sampled low
//   uart_rx_break     one-cycle pulse with frame_err when the payload is all zero
interface uart_rx_if #(
    parameter int unsigned PAYLOAD_BITS = 8
);
    logic                    uart_rxd;
    logic                    uart_rx_en;
    logic                    uart_rx_valid;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    uart_rx_frame_err;
    logic                    uart_rx_break;

    // Receiver side
    modport slave (
        input  uart_rxd,
        input  uart_rx_en,
        output uart_rx_valid,
        output uart_rx_data,
        output uart_rx_frame_err,
        output uart_rx_break
    );

    // Line driver / frame consumer side
    modport master (
        output uart_rxd,
        output uart_rx_en,
        input  uart_rx_valid,
        input  uart_rx_data,
        input  uart_rx_frame_err,
        input  uart_rx_break
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Recovers frames of PAYLOAD_BITS data
// bits (LSB first) and STOP_BITS stop bits from an asynchronous line,
// sampling each bit at its centre, and reports good frames, framing errors
// and break conditions as registered one-cycle pulses.
//   clk     system clock
//   resetn  synchronous active-low reset
//   rx      uart_rx_if.slave (line, enable, data and status pulses)
module uart_rx #(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     resetn,
    uart_rx_if.slave rx
);

    localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int unsigned CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
    localparam int unsigned MAX_IDX        = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int unsigned IDX_W          = $clog2(MAX_IDX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              sync_q, sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    brk_q, brk_d;
    logic                    rxd_s;
    logic                    bit_end;
    logic                    stop_err;

    assign rxd_s    = sync_q[1];
    assign bit_end  = (cnt_q == CNT_W'(CYCLES_PER_BIT - 1));
    assign stop_err = err_q | ~rxd_s;

    // State and datapath registers; synchroniser resets to the idle level
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rx.uart_rxd};
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        err_d   = err_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx.uart_rx_en && !rxd_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            // Re-check the line half a bit in so short glitches are rejected
            S_START: begin
                if (cnt_q == CNT_W'(HALF_BIT)) begin
                    if (rxd_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // First bit received ends up in the LSB
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {rxd_s, shift_q[PAYLOAD_BITS-1:1]};
                    cnt_d   = '0;
                    if (idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Leaves mid stop bit so a back-to-back start edge is not missed
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    err_d = stop_err;
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        data_d = shift_q;
                        idx_d  = '0;
                        if (stop_err) begin
                            ferr_d  = 1'b1;
                            brk_d   = (shift_q == '0);
                            state_d = S_WAIT_HIGH;
                        end else begin
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // A line held low must return high before a new start is accepted
            S_WAIT_HIGH: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx.uart_rx_valid     = valid_q;
    assign rx.uart_rx_data      = data_q;
    assign rx.uart_rx_frame_err = ferr_q;
    assign rx.uart_rx_break     = brk_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives whole frames onto the line and predicts, from the frame
// contents and its start time alone, when each pulse must appear and what
// uart_rx_data must hold; a per-cycle compare process checks the receiver.
module tb_uart_rx;

    localparam int unsigned CLK_HZ   = 50_000_000;
    localparam int unsigned BIT_RATE = 5_000_000;
    localparam int unsigned PB       = 8;
    localparam int unsigned SB       = 1;
    localparam int          CPB      = CLK_HZ / BIT_RATE;
    localparam int          HALF     = CPB / 2;
    // Start bit driven after cycle n: sampled at n+1, two sync flops, one
    // cycle to leave idle, HALF+1 to the start centre, (PB+SB)*CPB to the
    // last stop centre: the pulse is visible at cycle n + 4 + HALF + (PB+SB)*CPB.
    localparam int          EV_LAT   = 4 + HALF + (PB + SB) * CPB;

    typedef struct packed {
        logic          v;
        logic          fe;
        logic          br;
        logic [PB-1:0] d;
    } ev_t;

    logic clk;
    logic resetn;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    int   n_valid;
    int   n_ferr;
    int   n_brk;
    int   exp_valid;
    int   last_valid_cyc;
    bit   run_chk;
    logic [PB-1:0] exp_data;
    ev_t  evq[int];
    bit   rst_at[int];

    uart_rx_if #(.PAYLOAD_BITS(PB)) rx_if ();

    uart_rx #(
        .BIT_RATE    (BIT_RATE),
        .CLK_HZ      (CLK_HZ),
        .PAYLOAD_BITS(PB),
        .STOP_BITS   (SB)
    ) u_dut (
        .clk   (clk),
        .resetn(resetn),
        .rx    (rx_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the predicted event timeline
    always @(negedge clk) begin
        ev_t e;
        e = '0;
        if (run_chk) begin
            if (rst_at.exists(cyc)) exp_data = '0;
            if (evq.exists(cyc)) begin
                e        = evq[cyc];
                exp_data = e.d;
            end
            chk("valid", 32'(rx_if.uart_rx_valid), 32'(e.v));
            chk("frame_err", 32'(rx_if.uart_rx_frame_err), 32'(e.fe));
            chk("break", 32'(rx_if.uart_rx_break), 32'(e.br));
            chk("data", 32'(rx_if.uart_rx_data), 32'(exp_data));
            if (rx_if.uart_rx_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (rx_if.uart_rx_frame_err === 1'b1) n_ferr++;
            if (rx_if.uart_rx_break === 1'b1) n_brk++;
        end
    end

    task automatic idle(input int n);
        rx_if.uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one full frame; schedules its outcome when expect_rx is set
    task automatic send_frame(input logic [PB-1:0] d, input bit stop_ok, input bit expect_rx,
                              output int n0);
        ev_t e;
        n0 = cyc;
        rx_if.uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < int'(PB); i++) begin
            rx_if.uart_rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (expect_rx) begin
            e.v  = stop_ok;
            e.fe = !stop_ok;
            e.br = !stop_ok && (d == '0);
            e.d  = d;
            evq[n0 + EV_LAT] = e;
            if (stop_ok) exp_valid++;
        end
        rx_if.uart_rxd = stop_ok;
        repeat (CPB * int'(SB)) @(negedge clk);
        rx_if.uart_rxd = 1'b1;
    endtask

    initial begin
        int   n0;
        int   v0, f0, b0;
        bit   prev_err;
        logic [PB-1:0] d;
        bit   ok;
        ev_t  e;

        cyc = 0; n_cmp = 0; n_bad = 0; n_valid = 0; n_ferr = 0; n_brk = 0;
        exp_valid = 0; last_valid_cyc = -1; run_chk = 0; exp_data = '0;
        resetn = 1'b0;
        rx_if.uart_rxd   = 1'b1;
        rx_if.uart_rx_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(rx_if.uart_rx_data), 32'h0);
        chk("reset_valid", 32'(rx_if.uart_rx_valid), 32'h0);
        run_chk = 1;
        resetn  = 1'b1;
        idle(5);

        // 1: single frame, pulse exactly 99 cycles after the start bit is driven
        send_frame(8'hA5, 1'b1, 1'b1, n0);
        idle(20);
        chk("s1_data", 32'(rx_if.uart_rx_data), 32'hA5);
        chk("s1_count", 32'(n_valid), 32'd1);
        chk("s1_latency", 32'(last_valid_cyc - n0), 32'd99);

        // 2: back-to-back frames
        send_frame(8'h00, 1'b1, 1'b1, n0);
        send_frame(8'hFF, 1'b1, 1'b1, n0);
        send_frame(8'h3C, 1'b1, 1'b1, n0);
        idle(20);
        chk("s2_count", 32'(n_valid), 32'd4);
        chk("s2_data", 32'(rx_if.uart_rx_data), 32'h3C);

        // 3: short glitch is ignored, next frame received
        rx_if.uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(2 * CPB);
        chk("s3_glitch", 32'(n_valid + n_ferr), 32'd4);
        send_frame(8'h5A, 1'b1, 1'b1, n0);
        idle(20);
        chk("s3_data", 32'(rx_if.uart_rx_data), 32'h5A);

        // 4: low stop bit
        send_frame(8'h81, 1'b0, 1'b1, n0);
        idle(CPB);
        chk("s4_ferr", 32'(n_ferr), 32'd1);
        chk("s4_brk", 32'(n_brk), 32'd0);
        chk("s4_data", 32'(rx_if.uart_rx_data), 32'h81);
        send_frame(8'h12, 1'b1, 1'b1, n0);
        idle(20);
        chk("s4_next", 32'(rx_if.uart_rx_data), 32'h12);

        // 5: line held low for 30 bit times gives one break, no retrigger
        e = '{v: 1'b0, fe: 1'b1, br: 1'b1, d: '0};
        evq[cyc + EV_LAT] = e;
        rx_if.uart_rxd = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        idle(2 * CPB);
        chk("s5_ferr", 32'(n_ferr), 32'd2);
        chk("s5_brk", 32'(n_brk), 32'd1);
        chk("s5_data", 32'(rx_if.uart_rx_data), 32'h0);

        // 6: reset mid-frame abandons it
        rx_if.uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        d = 8'h77;
        for (int i = 0; i < 4; i++) begin
            rx_if.uart_rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
        rst_at[cyc + 1] = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        rx_if.uart_rxd = 1'b1;
        resetn = 1'b1;
        chk("s6_rst_data", 32'(rx_if.uart_rx_data), 32'h0);
        idle(CPB * 12);
        chk("s6_nopulse", 32'(n_valid), 32'd6);
        send_frame(8'h42, 1'b1, 1'b1, n0);
        idle(20);
        chk("s6_data", 32'(rx_if.uart_rx_data), 32'h42);

        // 6b: disabled receiver ignores a frame
        rx_if.uart_rx_en = 1'b0;
        idle(2);
        send_frame(8'h33, 1'b1, 1'b0, n0);
        idle(20);
        rx_if.uart_rx_en = 1'b1;
        chk("s6_en_count", 32'(n_valid), 32'd7);
        chk("s6_en_data", 32'(rx_if.uart_rx_data), 32'h42);

        // Randomized frames, gaps, stop errors and glitches
        prev_err = 1'b0;
        v0 = n_valid; f0 = n_ferr; b0 = n_brk;
        for (int k = 0; k < 30; k++) begin
            idle((prev_err ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3))) * CPB);
            if ($urandom_range(0, 4) == 0) begin
                rx_if.uart_rxd = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                idle(2 * CPB);
            end
            d  = ($urandom_range(0, 5) == 0) ? '0 : PB'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok, 1'b1, n0);
            prev_err = !ok;
        end
        idle(EV_LAT + 20);
        chk("rand_valid_total", 32'(n_valid), 32'(exp_valid));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
